// File: rtl/wb_gpio_bridge.sv
// Wishbone slave exposing N_IO pad channels as output, output-enable,
// synchronised input and edge-interrupt registers.
module wb_gpio_bridge #(
  parameter int          N_IO        = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [N_IO-1:0] io_in,
  output logic [N_IO-1:0] io_out,
  output logic [N_IO-1:0] io_oeb,
  output logic            user_irq
);

  typedef enum logic [5:0] {
    REG_DATA_OUT   = 6'h00,
    REG_OEB        = 6'h01,
    REG_DATA_IN    = 6'h02,
    REG_IRQ_EN     = 6'h03,
    REG_EDGE_SEL   = 6'h04,
    REG_IRQ_STATUS = 6'h05
  } reg_off_e;

  logic [N_IO-1:0] data_out, oeb, irq_en, edge_sel, irq_status;
  logic [N_IO-1:0] prev, sync_last, edge_ev, status_next;
  logic [SYNC_STAGES-1:0][N_IO-1:0] sync_q;
  logic            ack_q;
  logic [31:0]     dat_q, rdata, wmask;
  logic [5:0]      word;
  logic            accept, wr;
  logic            unused_adr;

  function automatic logic [31:0] widen(input logic [N_IO-1:0] v);
    logic [31:0] w;
    w = '0;
    w[N_IO-1:0] = v;
    return w;
  endfunction

  // Byte-lane merge of the bus write data into a register; bits >= N_IO drop out.
  function automatic logic [N_IO-1:0] merge(input logic [N_IO-1:0] old,
                                            input logic [31:0] d,
                                            input logic [31:0] m);
    logic [31:0] r;
    r = (widen(old) & ~m) | (d & m);
    return r[N_IO-1:0];
  endfunction

  assign unused_adr = ^wbs_adr_i[1:0];
  assign word       = wbs_adr_i[7:2];
  assign wmask      = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign accept     = wbs_cyc_i & wbs_stb_i & ~ack_q &
                      (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr         = accept & wbs_we_i;

  assign sync_last  = sync_q[SYNC_STAGES-1];
  assign edge_ev    = (edge_sel & sync_last & ~prev) | (~edge_sel & ~sync_last & prev);

  always_comb begin
    rdata = '0;
    case (word)
      REG_DATA_OUT:   rdata = widen(data_out);
      REG_OEB:        rdata = widen(oeb);
      REG_DATA_IN:    rdata = widen(sync_last);
      REG_IRQ_EN:     rdata = widen(irq_en);
      REG_EDGE_SEL:   rdata = widen(edge_sel);
      REG_IRQ_STATUS: rdata = widen(irq_status);
      default:        rdata = '0;
    endcase
  end

  // Clear is applied before the set so a coincident event survives the W1C.
  always_comb begin
    status_next = irq_status;
    if (wr && word == REG_IRQ_STATUS)
      status_next = status_next & ~merge('0, wbs_dat_i, wmask);
    status_next = status_next | (edge_ev & irq_en);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      data_out   <= '0;
      oeb        <= '1;
      irq_en     <= '0;
      edge_sel   <= '0;
      irq_status <= '0;
      sync_q     <= '0;
      prev       <= '0;
    end else begin
      ack_q      <= accept;
      dat_q      <= (accept && !wbs_we_i) ? rdata : '0;
      sync_q[0]  <= io_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev       <= sync_last;
      irq_status <= status_next;
      if (wr) begin
        case (word)
          REG_DATA_OUT: data_out <= merge(data_out, wbs_dat_i, wmask);
          REG_OEB:      oeb      <= merge(oeb, wbs_dat_i, wmask);
          REG_IRQ_EN:   irq_en   <= merge(irq_en, wbs_dat_i, wmask);
          REG_EDGE_SEL: edge_sel <= merge(edge_sel, wbs_dat_i, wmask);
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = data_out;
  assign io_oeb    = oeb;
  assign user_irq  = |(irq_status & irq_en);

endmodule

// File: tb/tb_wb_gpio_bridge.sv
// Directed self-checking bench for wb_gpio_bridge (N_IO=16, SYNC_STAGES=2).
module tb_wb_gpio_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic [15:0] io_in = '0;
  logic [15:0] io_out, io_oeb;
  logic        irq;
  logic [31:0] r;
  int          total = 0, bad = 0, acks;

  always #5 clk = ~clk;

  wb_gpio_bridge #(
    .N_IO(16),
    .BASE_ADDR(32'h3000_0000),
    .SYNC_STAGES(2)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .user_irq(irq)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Strobe stays high through the ack cycle so the single-cycle ack is exercised.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    @(posedge clk); #1;
    check_val("ack_rise", 32'(ack), 32'd1);
    rd = dat_r;
    @(posedge clk); #1;
    check_val("ack_single", 32'(ack), 32'd0);
    check_val("dat_idle", dat_r, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, s, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    wb_xfer(1'b0, a, 32'd0, 4'hF, rd);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_oeb", 32'(io_oeb), 32'h0000_FFFF);
    check_val("rst_out", 32'(io_out), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_oeb", 32'(io_oeb), 32'h0000_FFFF);
    wb_read(32'h3000_0004, r);
    check_val("oeb_read", r, 32'h0000_FFFF);

    wb_write(32'h3000_0000, 32'hA5A5_1234, 4'b0001);
    check_val("lane0_out", 32'(io_out), 32'h0000_0034);
    wb_write(32'h3000_0000, 32'h0000_AB00, 4'b0010);
    check_val("lane1_out", 32'(io_out), 32'h0000_AB34);
    wb_read(32'h3000_0000, r);
    check_val("dout_read", r, 32'h0000_AB34);
    wb_write(32'h3000_0004, 32'h0000_0000, 4'hF);
    check_val("oeb_zero", 32'(io_oeb), 32'd0);

    // DATA_IN visible only after two synchroniser edges
    io_in = 16'h8001;
    wb_read(32'h3000_0008, r);
    check_val("din_edge1", r, 32'd0);
    wb_read(32'h3000_0008, r);
    check_val("din_edge3", r, 32'h0000_8001);
    io_in = 16'h0000;
    @(posedge clk); #1;
    wb_read(32'h3000_0008, r);
    check_val("din_edge2", r, 32'h0000_8001);
    wb_read(32'h3000_0008, r);
    check_val("din_edge4", r, 32'd0);
    wb_write(32'h3000_0008, 32'hFFFF_FFFF, 4'hF);
    wb_read(32'h3000_0008, r);
    check_val("din_ro", r, 32'd0);

    // rising-edge interrupt
    wb_write(32'h3000_000C, 32'd1, 4'hF);
    wb_write(32'h3000_0010, 32'd1, 4'hF);
    io_in = 16'h0001;
    @(posedge clk); #1;
    check_val("irq_e1", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check_val("irq_e2", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check_val("irq_e3", 32'(irq), 32'd1);
    wb_read(32'h3000_0014, r);
    check_val("status_set", r, 32'd1);
    wb_write(32'h3000_0014, 32'd1, 4'hF);
    check_val("irq_w1c", 32'(irq), 32'd0);
    wb_read(32'h3000_0014, r);
    check_val("status_clr", r, 32'd0);

    // falling edge with IRQ_EN=0 must not set status
    wb_write(32'h3000_000C, 32'd0, 4'hF);
    wb_write(32'h3000_0010, 32'd0, 4'hF);
    io_in = 16'h0000;
    repeat (4) @(posedge clk);
    #1;
    wb_read(32'h3000_0014, r);
    check_val("fall_masked", r, 32'd0);

    // falling-edge event, then masking via IRQ_EN keeps status
    wb_write(32'h3000_000C, 32'd1, 4'hF);
    io_in = 16'h0001;
    repeat (4) @(posedge clk);
    #1;
    wb_read(32'h3000_0014, r);
    check_val("rise_ignored", r, 32'd0);
    io_in = 16'h0000;
    repeat (4) @(posedge clk);
    #1;
    check_val("fall_irq", 32'(irq), 32'd1);
    wb_write(32'h3000_000C, 32'd0, 4'hF);
    check_val("irq_masked", 32'(irq), 32'd0);
    wb_read(32'h3000_0014, r);
    check_val("status_kept", r, 32'd1);
    wb_write(32'h3000_0014, 32'd1, 4'hF);
    wb_read(32'h3000_0014, r);
    check_val("status_clr2", r, 32'd0);

    // W1C coincident with a new rising event: set wins
    wb_write(32'h3000_0010, 32'd1, 4'hF);
    wb_write(32'h3000_000C, 32'd1, 4'hF);
    io_in = 16'h0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wb_write(32'h3000_0014, 32'd1, 4'hF);
    wb_read(32'h3000_0014, r);
    check_val("set_wins", r, 32'd1);
    check_val("set_wins_irq", 32'(irq), 32'd1);

    // non-matching window is never acknowledged
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3100_0000;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check_val("nomatch_ack", 32'(acks), 32'd0);
    cyc = 1'b0; stb = 1'b0;

    wb_read(32'h3000_0020, r);
    check_val("reserved_rd", r, 32'd0);

    // reset during the ack cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000; dat_w = 32'h0000_FFFF; sel = 4'hF;
    @(posedge clk); #1;
    check_val("mid_ack", 32'(ack), 32'd1);
    check_val("mid_out", 32'(io_out), 32'h0000_FFFF);
    rst = 1'b1;
    #1;
    check_val("rst_ack_drop", 32'(ack), 32'd0);
    check_val("rst_dat", dat_r, 32'd0);
    check_val("rst_out2", 32'(io_out), 32'd0);
    check_val("rst_oeb2", 32'(io_oeb), 32'h0000_FFFF);
    check_val("rst_irq2", 32'(irq), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wb_read(32'h3000_0004, r);
    check_val("oeb_after_rst", r, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
